// File: rtl/keypad_scan_ctrl_pkg.sv
// keypad_scan_ctrl_pkg: shared states, geometry and helpers for the keypad scanner
package keypad_scan_ctrl_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_CODE_W = 4;
  localparam logic [NUM_ROWS-1:0] ROW_IDLE = 4'b1111;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/keypad_scan_ctrl_sync2.sv
// keypad_scan_ctrl_sync2: two-flop synchronizer, resets to all-ones (idle pulled-up lines)
module keypad_scan_ctrl_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1, r_s2;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end
  assign o_q = r_s2;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with a single shared press/release debounce counter
module keypad_scan_ctrl
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [NUM_COLS-1:0]   col_n,
  output logic [NUM_ROWS-1:0]   row_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);
  localparam int CNT_W = $clog2(max2(SCAN_CYCLES, DEBOUNCE_CYCLES));
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [1:0]              r_row_idx, w_row_idx_nxt;
  logic [1:0]              r_col_idx, w_col_idx_nxt;
  logic [NUM_ROWS-1:0]     r_row_n, w_row_n_nxt;
  logic [KEY_CODE_W-1:0]   r_key_code, w_key_code_nxt;
  logic                    r_key_valid, w_key_valid_nxt;
  logic                    r_key_held, w_key_held_nxt;
  logic [NUM_COLS-1:0]     w_col_s;
  logic                    w_any;
  logic                    w_sel_high;
  logic [1:0]              w_low_col;
  keypad_scan_ctrl_sync2 #(.W(NUM_COLS)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .i_d  (col_n),
    .o_q  (w_col_s)
  );
  assign w_any      = ~&w_col_s;
  assign w_sel_high = w_col_s[r_col_idx];
  assign w_low_col  = !w_col_s[0] ? 2'd0 : !w_col_s[1] ? 2'd1 : !w_col_s[2] ? 2'd2 : 2'd3;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= SCAN;
      r_cnt       <= '0;
      r_row_idx   <= '0;
      r_col_idx   <= '0;
      r_row_n     <= 4'b1110;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_col_idx   <= w_col_idx_nxt;
      r_row_n     <= w_row_n_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
    end
  end
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + 1'b1;
    w_row_idx_nxt   = r_row_idx;
    w_col_idx_nxt   = r_col_idx;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;
    if (!en) begin
      w_state_nxt    = SCAN;
      w_cnt_nxt      = '0;
      w_row_idx_nxt  = '0;
      w_key_held_nxt = 1'b0;
    end else begin
      case (r_state)
        SCAN: if (r_cnt == SCAN_LAST) begin
          w_cnt_nxt = '0;
          if (w_any) begin
            w_col_idx_nxt = w_low_col;
            w_state_nxt   = DEBOUNCE;
          end else w_row_idx_nxt = r_row_idx + 2'd1;
        end
        DEBOUNCE: if (w_sel_high) begin
          w_state_nxt   = SCAN;
          w_cnt_nxt     = '0;
          w_row_idx_nxt = r_row_idx + 2'd1;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt     = PRESSED;
          w_cnt_nxt       = '0;
          w_key_valid_nxt = 1'b1;
          w_key_code_nxt  = {r_row_idx, r_col_idx};
          w_key_held_nxt  = 1'b1;
        end
        PRESSED: begin
          w_cnt_nxt = '0;
          if (w_sel_high) w_state_nxt = RELEASE;
        end
        RELEASE: if (!w_sel_high) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt    = SCAN;
          w_cnt_nxt      = '0;
          w_key_held_nxt = 1'b0;
          w_row_idx_nxt  = r_row_idx + 2'd1;
        end
      endcase
    end
    // row drive follows the next row index so it moves on the same edge as the FSM
    w_row_n_nxt = en ? ~(NUM_ROWS'(1) << w_row_idx_nxt) : ROW_IDLE;
  end
  assign row_n     = r_row_n;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
endmodule
